// File: rtl/registers_pkg.sv
// -----------------------------------------------------------------------------
// registers_pkg
//   Shared constants and decode helpers for the four-entry register file.
//   Upstream writeback logic imports this package to drive WR_NONE when a
//   write must be suppressed, so it needs no separate write-enable.
// -----------------------------------------------------------------------------
package registers_pkg;

  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;
  localparam int WR_CODE_W = 3;

  // Canonical "no write" destination code. Any code with the top bit set
  // (4..7) suppresses the write, but drivers should use this one.
  localparam logic [WR_CODE_W-1:0] WR_NONE = 3'd4;

  // A destination code requests a write only when its top bit is clear.
  function automatic logic wr_en(input logic [WR_CODE_W-1:0] code);
    return ~code[WR_CODE_W-1];
  endfunction

  // Register index carried in the low bits of a destination code.
  function automatic logic [REG_IDX_W-1:0] wr_idx(input logic [WR_CODE_W-1:0] code);
    return code[REG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/registers.sv
// -----------------------------------------------------------------------------
// registers
//   Four N-bit general-purpose registers with two combinational read ports
//   and one synchronous write port.
//
//   Ports
//     clk  in   rising-edge clock for all state updates
//     rst  in   synchronous active-high reset; clears R0..R3, beats a write
//     r1   in   read port 1 index (0..3)
//     r2   in   read port 2 index (0..3)
//     w1   in   write destination code: 0..3 writes R[w1], 4..7 no write
//     w    in   write data
//     v1   out  R[r1], combinational
//     v2   out  R[r2], combinational
//
//   There is no write-to-read bypass: a read of the register being written
//   shows the old value until the edge. R0 is an ordinary register.
// -----------------------------------------------------------------------------
module registers
  import registers_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] r1,
  input  logic [REG_IDX_W-1:0] r2,
  input  logic [WR_CODE_W-1:0] w1,
  input  logic [N-1:0]         w,
  output logic [N-1:0]         v1,
  output logic [N-1:0]         v2
);

  logic [N-1:0] regs [NUM_REGS];

  // Write port: reset clears every entry and discards a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en(w1)) begin
      regs[wr_idx(w1)] <= w;
    end
  end

  // Read ports: plain muxes on the stored state.
  assign v1 = regs[r1];
  assign v2 = regs[r2];

endmodule

// File: tb/tb_registers.sv
// -----------------------------------------------------------------------------
// tb_registers
//   Directed and randomized bench for the register file. A four-entry array
//   holds the expected contents and is updated by the architectural rules:
//   reset clears all, codes 0..3 write one entry, codes 4..7 change nothing.
// -----------------------------------------------------------------------------
module tb_registers;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  r1, r2;
  logic [2:0]  w1;
  logic [31:0] w;
  logic [31:0] v1, v2;

  logic [31:0] model [4];
  int          n_checks = 0;
  int          n_fails  = 0;

  registers #(.N(32)) dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .w1(w1), .w(w), .v1(v1), .v2(v2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same inputs the DUT samples.
  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
    end else if (w1 < 3'd4) begin
      model[w1] = w;
    end
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    r1 = a;
    r2 = b;
    #1;
  endtask

  // Compare every register on both ports against the model.
  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(3 - i));
      check($sformatf("%s_v1_R%0d", tag, i), v1, model[i]);
      check($sformatf("%s_v2_R%0d", tag, 3 - i), v2, model[3 - i]);
    end
  endtask

  initial begin
    logic [31:0] exp_v1, exp_v2;

    // Reset beats a simultaneous write.
    rst = 1'b1; w1 = 3'd0; w = 32'hDEADBEEF; r1 = 2'd0; r2 = 2'd3;
    edge_step();
    rst = 1'b0; w1 = 3'd4;
    rd(2'd0, 2'd3);
    check("reset_v1", v1, 32'h0);
    check("reset_v2", v2, 32'h0);

    // Sequential writes, one per edge.
    w1 = 3'd0; w = 32'd1;          edge_step();
    w1 = 3'd1; w = 32'd3;          edge_step();
    w1 = 3'd2; w = 32'd7;          edge_step();
    w1 = 3'd3; w = 32'hFFFFFFFF;   edge_step();
    w1 = 3'd4;                     edge_step();
    rd(2'd0, 2'd1);
    check("seq_r0", v1, 32'd1);
    check("seq_r1", v2, 32'd3);
    rd(2'd2, 2'd3);
    check("seq_r2", v1, 32'd7);
    check("seq_r3", v2, 32'hFFFFFFFF);

    // No-write codes leave everything intact.
    w1 = 3'd4; w = 32'd100; edge_step();
    w1 = 3'd7; w = 32'd55;  edge_step();
    rd(2'd0, 2'd1);
    check("nowr_r0", v1, 32'd1);
    check("nowr_r1", v2, 32'd3);
    rd(2'd2, 2'd3);
    check("nowr_r2", v1, 32'd7);
    check("nowr_r3", v2, 32'hFFFFFFFF);

    // Read-during-write shows the old value until the edge.
    rd(2'd3, 2'd0);
    w1 = 3'd3; w = 32'd0;
    #1;
    check("rdw_before", v1, 32'hFFFFFFFF);
    edge_step();
    check("rdw_after", v1, 32'd0);
    w1 = 3'd4; w = 32'd100;
    edge_step();
    check("rdw_hold", v1, 32'd0);

    // Both ports on the same register, then a combinational index change.
    rd(2'd2, 2'd2);
    check("same_v1", v1, 32'd7);
    check("same_v2", v2, 32'd7);
    r1 = 2'd1;
    #1;
    check("idxchg_v1", v1, 32'd3);
    check("idxchg_v2", v2, 32'd7);

    // Reset mid-operation discards the concurrent write.
    rst = 1'b1; w1 = 3'd1; w = 32'h12345678;
    edge_step();
    rst = 1'b0; w1 = 3'd4;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(i));
      check($sformatf("midrst_R%0d", i), v1, 32'h0);
    end

    // Randomized traffic against the model, checking reads before and after
    // every edge (the pre-edge check covers read-during-write).
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 29) == 0);
      w1  = 3'($urandom_range(0, 7));
      w   = $urandom;
      rd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      exp_v1 = model[r1];
      exp_v2 = model[r2];
      check("rnd_pre_v1", v1, exp_v1);
      check("rnd_pre_v2", v2, exp_v2);
      edge_step();
      check("rnd_post_v1", v1, model[r1]);
      check("rnd_post_v2", v2, model[r2]);
    end
    rst = 1'b0; w1 = 3'd4;
    edge_step();
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/registers.md
Name: registers

Overview:
- Small general-purpose register file for the CPU datapath: four N-bit registers, two combinational read ports, one synchronous write port.
- Sits between the decode stage (supplies register indices) and the ALU/writeback path (consumes v1/v2, supplies w).
- Write port uses a 3-bit destination code; codes 4..7 mean "no write", so writeback can be suppressed without a separate enable.

Parameters:
- N, 32, data width of each register and of w, v1, v2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- r1  input  2  read-port-1 register index (0..3).
- r2  input  2  read-port-2 register index (0..3).
- w1  input  3  write destination code: 0..3 selects a register; 4..7 performs no write.
- w  input  N  write data.
- v1  output  N  contents of register r1.
- v2  output  N  contents of register r2.

Behaviour:
- Storage: four N-bit registers, R0..R3. No register is hardwired to zero; R0 is writable like the others.
- Reset: on a rising clk edge with rst=1, R0..R3 become 0. Consequently v1 = v2 = 0 after that edge.
- rst has priority over a write in the same cycle. That write is discarded.
- Write: on a rising clk edge with rst=0 and w1[2]=0, register R[w1[1:0]] takes the value of w.
- On a rising clk edge with rst=0 and w1[2]=1 (codes 4..7), no register changes.
- Exactly one register is written per cycle at most. All other registers hold.
- Read: v1 = R[r1] and v2 = R[r2], purely combinational (zero-cycle latency from r1/r2 change).
- Reads are unaffected by clk except through register updates.
- Both ports may select the same register simultaneously; each returns its full value.
- Read-during-write: there is no write-to-read bypass.
  - In the cycle where w1 targets the register being read, v1/v2 show the old value until the clock edge.
  - The new value appears immediately after the edge.
- Power-up contents before the first reset are undefined (X in simulation). Users must assert rst at least one cycle before relying on reads.
- No handshake, no stall; w1 and w are sampled every edge.
- Data is stored verbatim: no sign extension and no width conversion.

Decomposition:
- Shared package, e.g. regfile_pkg:
  - NUM_REGS = 4
  - REG_IDX_W = 2
  - WR_CODE_W = 3
  - WR_NONE = 3'd4 (canonical "no write" code for upstream drivers)
- No sub-module: a single module holding an array of four N-bit registers, a write-decode always_ff block, and two combinational read muxes.

Test Plan:
- Reset: assert rst for one edge with w1=0, w=32'hDEADBEEF. Then set r1=0, r2=3 → v1=0 and v2=0 (the write is suppressed by reset).
- Sequential writes (one per edge):
  - w1=0, w=1
  - w1=1, w=3
  - w1=2, w=7
  - w1=3, w=32'hFFFFFFFF
  - then w1=4
  - Read r1=0, r2=1 → v1=1, v2=3.
  - Read r1=2, r2=3 → v1=7, v2=32'hFFFFFFFF.
- No-write code: after the above, drive w1=4 with w=100 for one edge, then w1=7 with w=55 for one edge. Reads of R0..R3 remain 1, 3, 7, FFFFFFFF.
- Overwrite and read-during-write: with r1=3 held, drive w1=3, w=0.
  - Before the edge: v1=FFFFFFFF.
  - After the edge: v1=0.
  - Then w1=4, w=100: v1 stays 0.
- Same-index dual read: r1=r2=2 → v1=v2=7. Changing r1 to 1 with no clock edge → v1=3 immediately, v2=7.
- Reset mid-operation: with registers loaded, assert rst while w1=1, w=32'h12345678 → all four registers read 0 after the edge.
